// File: rtl/arb8_rr_32bit_pkg.sv
// Shared types, sizes and helpers for the 8-way round-robin burst arbiter.
package arb8_rr_32bit_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  function automatic sel_t onehot_to_bin(input req_vec_t oh);
    sel_t b;
    b = {SEL_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        b = b | sel_t'(i);
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/arb8_rr_32bit_if.sv
// Requester/consumer bundle of the arbiter; master is the arbiter's view.
interface arb8_rr_32bit_if;
  import arb8_rr_32bit_pkg::*;

  req_vec_t            req;
  req_vec_t            last;
  logic [DATA_W-1:0]   in0;
  logic [DATA_W-1:0]   in1;
  logic [DATA_W-1:0]   in2;
  logic [DATA_W-1:0]   in3;
  logic [DATA_W-1:0]   in4;
  logic [DATA_W-1:0]   in5;
  logic [DATA_W-1:0]   in6;
  logic [DATA_W-1:0]   in7;
  req_vec_t            ack;
  req_vec_t            grant;
  sel_t                select;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;
  logic                busy;

  modport master (
    input  req, last, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    output ack, grant, select, out_data, out_valid, out_last, busy
  );

  modport slave (
    output req, last, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    input  ack, grant, select, out_data, out_valid, out_last, busy
  );

endinterface

// File: rtl/arb8_rr_32bit_mux.sv
// 8:1 data mux steered by the arbiter's registered select.
module mux8_32bit
  import arb8_rr_32bit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  sel_t                  i_select,
  input  logic [DATA_WIDTH-1:0] i_in0,
  input  logic [DATA_WIDTH-1:0] i_in1,
  input  logic [DATA_WIDTH-1:0] i_in2,
  input  logic [DATA_WIDTH-1:0] i_in3,
  input  logic [DATA_WIDTH-1:0] i_in4,
  input  logic [DATA_WIDTH-1:0] i_in5,
  input  logic [DATA_WIDTH-1:0] i_in6,
  input  logic [DATA_WIDTH-1:0] i_in7,
  output logic [DATA_WIDTH-1:0] o_data
);

  // select the granted requester's data
  always_comb begin
    o_data = i_in0;
    case (i_select)
      3'd0:    o_data = i_in0;
      3'd1:    o_data = i_in1;
      3'd2:    o_data = i_in2;
      3'd3:    o_data = i_in3;
      3'd4:    o_data = i_in4;
      3'd5:    o_data = i_in5;
      3'd6:    o_data = i_in6;
      3'd7:    o_data = i_in7;
      default: o_data = i_in0;
    endcase
  end

endmodule

// File: rtl/arb8_rr_32bit.sv
// Round-robin arbiter sharing one 32-bit valid/ready channel among 8 burst
// requesters; a grant lasts until last, a beat-limit timeout, or req drop.
module arb8_rr_32bit
  import arb8_rr_32bit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic             clock,
  input  logic             reset,
  arb8_rr_32bit_if.master  bus
);

  localparam int                CNT_W      = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]  BEAT_LIMIT = CNT_W'(MAX_BEATS);

  state_t            r_state;
  state_t            w_state_nxt;
  req_vec_t          r_grant;
  req_vec_t          w_grant_nxt;
  sel_t              r_select;
  sel_t              w_select_nxt;
  sel_t              r_ptr;
  sel_t              w_ptr_nxt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_beat_cnt_nxt;
  logic [CNT_W-1:0]  w_beat_inc;

  req_vec_t          w_pick_grant;
  sel_t              w_pick_sel;
  sel_t              w_idx;
  logic              w_pick_found;

  logic              w_req_sel;
  logic              w_last_sel;
  logic              w_valid;
  logic              w_xfer;
  logic              w_release;
  logic [DATA_WIDTH-1:0] w_mux_data;

  // first requesting index searching upward from the round-robin pointer
  always_comb begin
    w_pick_grant = {NUM_REQ{1'b0}};
    w_pick_found = 1'b0;
    w_idx        = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = r_ptr + sel_t'(k);
      if (!w_pick_found && bus.req[w_idx]) begin
        w_pick_grant = req_vec_t'(8'h01) << w_idx;
        w_pick_found = 1'b1;
      end else begin
        w_pick_found = w_pick_found;
      end
    end
  end

  assign w_pick_sel = onehot_to_bin(w_pick_grant);

  assign w_req_sel  = bus.req[r_select];
  assign w_last_sel = bus.last[r_select];
  assign w_valid    = (r_state == BUSY) && w_req_sel;
  assign w_xfer     = w_valid && bus.out_ready;
  assign w_beat_inc = r_beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // a dropped request aborts; last and timeout together still release once
  assign w_release  = (r_state == BUSY) &&
                      (!w_req_sel ||
                       (w_xfer && (w_last_sel || (w_beat_inc == BEAT_LIMIT))));

  // next-state and next-register values for the grant FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_select_nxt   = r_select;
    w_ptr_nxt      = r_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt    = BUSY;
          w_grant_nxt    = w_pick_grant;
          w_select_nxt   = w_pick_sel;
          w_beat_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          w_state_nxt    = IDLE;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_state_nxt    = IDLE;
          w_grant_nxt    = {NUM_REQ{1'b0}};
          w_ptr_nxt      = r_select + 3'd1;
          w_beat_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_xfer) begin
          w_beat_cnt_nxt = w_beat_inc;
        end else begin
          w_beat_cnt_nxt = r_beat_cnt;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_grant_nxt    = {NUM_REQ{1'b0}};
        w_beat_cnt_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  // state and arbitration registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= {NUM_REQ{1'b0}};
      r_select   <= {SEL_W{1'b0}};
      r_ptr      <= {SEL_W{1'b0}};
      r_beat_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_select   <= w_select_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  mux8_32bit #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .i_select (r_select),
    .i_in0    (bus.in0),
    .i_in1    (bus.in1),
    .i_in2    (bus.in2),
    .i_in3    (bus.in3),
    .i_in4    (bus.in4),
    .i_in5    (bus.in5),
    .i_in6    (bus.in6),
    .i_in7    (bus.in7),
    .o_data   (w_mux_data)
  );

  // outputs are derived only from registered state plus the granted inputs
  assign bus.grant     = r_grant;
  assign bus.select    = r_select;
  assign bus.busy      = (r_state == BUSY);
  assign bus.out_valid = w_valid;
  assign bus.out_last  = w_valid && w_last_sel;
  assign bus.ack       = w_xfer ? r_grant : {NUM_REQ{1'b0}};
  assign bus.out_data  = w_mux_data;

endmodule

// File: tb/tb_arb8_rr_32bit.sv
// Scoreboard bench: an owner/pointer reference model predicts every cycle and
// every accepted beat; a negedge monitor pops and compares.
module tb_arb8_rr_32bit;

  localparam int MAXB = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  arb8_rr_32bit_if bus ();

  arb8_rr_32bit #(.DATA_WIDTH(32), .MAX_BEATS(MAXB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] din [8];
  assign bus.in0 = din[0];
  assign bus.in1 = din[1];
  assign bus.in2 = din[2];
  assign bus.in3 = din[3];
  assign bus.in4 = din[4];
  assign bus.in5 = din[5];
  assign bus.in6 = din[6];
  assign bus.in7 = din[7];

  typedef struct {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       busy;
    logic [7:0] ack;
  } cyc_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  cyc_t  cq[$];
  beat_t bq[$];

  int checks = 0;
  int errors = 0;
  int ack_cnt [8];

  // reference model: who owns the channel, where the search starts, beats taken
  int owner = -1;
  int ptr   = 0;
  int beats = 0;
  bit hold  = 1'b0;
  logic [31:0] held_d;
  logic        held_l;
  bit mon_en = 1'b0;
  bit fix7   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus; called at posedge+1, returns at the next posedge+1
  task automatic step(input logic [7:0] rq, input logic [7:0] ls_in, input logic rdy);
    logic [7:0] ls;
    cyc_t c;
    ls = ls_in;
    for (int i = 0; i < 8; i++) din[i] = $urandom;
    if (fix7) din[7] = 32'hDEADBEEF;
    if (hold && owner >= 0 && rq[owner]) begin
      din[owner] = held_d;
      ls[owner]  = held_l;
    end
    bus.req       = rq;
    bus.last      = ls;
    bus.out_ready = rdy;

    c.busy  = (owner >= 0);
    c.grant = (owner >= 0) ? (8'h01 << owner) : 8'h00;
    c.sel   = (owner >= 0) ? 3'(owner) : 3'd0;
    c.valid = (owner >= 0) && rq[owner];
    c.ack   = (c.valid && rdy) ? c.grant : 8'h00;
    cq.push_back(c);
    if (c.valid && rdy) bq.push_back('{din[owner], ls[owner]});
    hold = c.valid && !rdy;
    if (hold) begin
      held_d = din[owner];
      held_l = ls[owner];
    end

    if (owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (rq[(ptr + k) % 8]) begin
          owner = (ptr + k) % 8;
          beats = 0;
          break;
        end
      end
    end else begin
      bit rel;
      rel = 1'b0;
      if (!rq[owner]) rel = 1'b1;
      else if (rdy) begin
        beats++;
        if (ls[owner] || beats == MAXB) rel = 1'b1;
      end
      if (rel) begin
        ptr   = (owner + 1) % 8;
        owner = -1;
        beats = 0;
        hold  = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // monitor: compare each cycle's presentation and each accepted beat
  always @(negedge clock) begin
    if (mon_en) begin
      if (cq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cycle_queue: got empty expected an entry at %0t", $time);
      end else begin
        cyc_t c;
        c = cq.pop_front();
        check("grant", {24'h0, bus.grant}, {24'h0, c.grant});
        check("out_valid", {31'h0, bus.out_valid}, {31'h0, c.valid});
        check("busy", {31'h0, bus.busy}, {31'h0, c.busy});
        check("ack", {24'h0, bus.ack}, {24'h0, c.ack});
        if (c.busy) check("select", {29'h0, bus.select}, {29'h0, c.sel});
      end
      for (int i = 0; i < 8; i++) if (bus.ack[i]) ack_cnt[i]++;
      if (bus.out_valid && bus.out_ready) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_queue: got unexpected beat %h at %0t", bus.out_data, $time);
        end else begin
          beat_t b;
          b = bq.pop_front();
          check("out_data", bus.out_data, b.data);
          check("out_last", {31'h0, bus.out_last}, {31'h0, b.last});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      din[i]     = 32'h1000_0000 + i;
      ack_cnt[i] = 0;
    end
    reset         = 1'b1;
    bus.req       = 8'hFF;
    bus.last      = 8'h01;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_grant", {24'h0, bus.grant}, 32'h0);
    check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_data", bus.out_data, din[0]);
    reset  = 1'b0;
    mon_en = 1'b1;

    // first grant after reset, then round-robin advance
    step(8'hFF, 8'h01, 1'b1);
    check("first_grant", {24'h0, bus.grant}, 32'h01);
    step(8'hFF, 8'h01, 1'b1);
    step(8'hFF, 8'h01, 1'b1);
    check("second_grant", {24'h0, bus.grant}, 32'h02);
    step(8'h02, 8'h02, 1'b1);

    // pointer wrap 7 -> 0
    fix7 = 1'b1;
    step(8'h40, 8'h40, 1'b1);
    step(8'h40, 8'h40, 1'b1);
    step(8'h81, 8'h81, 1'b1);
    check("wrap_grant7", {24'h0, bus.grant}, 32'h80);
    check("wrap_data7", bus.out_data, 32'hDEADBEEF);
    step(8'h81, 8'h81, 1'b1);
    step(8'h81, 8'h81, 1'b1);
    check("wrap_grant0", {24'h0, bus.grant}, 32'h01);
    step(8'h01, 8'h01, 1'b1);
    fix7 = 1'b0;

    // beat-limit timeout
    ack_cnt[3] = 0;
    repeat (1 + MAXB) step(8'h08, 8'h00, 1'b1);
    check("timeout_acks", ack_cnt[3], MAXB);
    check("timeout_idle", {31'h0, bus.busy}, 32'h0);
    step(8'h18, 8'h18, 1'b1);
    check("timeout_ptr", {24'h0, bus.grant}, 32'h10);
    step(8'h18, 8'h18, 1'b1);

    // consumer stall
    ack_cnt[2] = 0;
    step(8'h04, 8'h04, 1'b1);
    repeat (5) step(8'h04, 8'h04, 1'b0);
    check("stall_acks", ack_cnt[2], 0);
    check("stall_grant", {24'h0, bus.grant}, 32'h04);
    check("stall_valid", {31'h0, bus.out_valid}, 32'h1);
    step(8'h04, 8'h04, 1'b1);
    check("stall_release_acks", ack_cnt[2], 1);
    check("stall_release_busy", {31'h0, bus.busy}, 32'h0);

    // requester abort after two beats
    ack_cnt[5] = 0;
    step(8'h20, 8'h00, 1'b1);
    repeat (2) step(8'h20, 8'h00, 1'b1);
    step(8'h00, 8'h00, 1'b1);
    check("abort_idle", {31'h0, bus.busy}, 32'h0);
    step(8'h60, 8'h00, 1'b1);
    check("abort_ptr", {24'h0, bus.grant}, 32'h40);
    check("abort_acks", ack_cnt[5], 2);
    step(8'h40, 8'h40, 1'b1);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic [7:0] rq;
      logic [7:0] ls;
      rq = 8'($urandom) & 8'($urandom);
      if (owner >= 0 && $urandom_range(0, 9) != 0) rq[owner] = 1'b1;
      for (int i = 0; i < 8; i++) ls[i] = ($urandom_range(0, 5) == 0);
      step(rq, ls, $urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 40 && owner >= 0; n++) step(8'h00, 8'h00, 1'b1);
    check("drain_idle", {31'h0, bus.busy}, 32'h0);

    // asynchronous reset in the middle of a burst
    repeat (3) step(8'h10, 8'h00, 1'b1);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("async_grant", {24'h0, bus.grant}, 32'h0);
    check("async_valid", {31'h0, bus.out_valid}, 32'h0);
    check("async_busy", {31'h0, bus.busy}, 32'h0);
    check("async_ack", {24'h0, bus.ack}, 32'h0);
    owner = -1; ptr = 0; beats = 0; hold = 1'b0;
    cq.delete();
    bq.delete();
    @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    step(8'h81, 8'h81, 1'b1);
    check("restart_ptr0", {24'h0, bus.grant}, 32'h01);
    step(8'h81, 8'h81, 1'b1);
    step(8'h00, 8'h00, 1'b1);

    @(negedge clock);
    mon_en = 1'b0;
    check("cq_empty", cq.size(), 0);
    check("bq_empty", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
